// File: rtl/axi_reg_slice.sv
// rtl/axi_reg_slice.sv - AXI4 register slice with per-channel skid buffer or bypass
//
// axi_reg_slice sits between a CPU-side AXI master (s_axi_*) and an interconnect
// slave port (m_axi_*). AW/W/AR flow s->m, B/R flow m->s. Each channel is either
// a 2-entry skid buffer (CH_MODE bit = 1) or a straight wire (bit = 0).
//   CH_MODE bits: [4]=AW [3]=W [2]=B [1]=AR [0]=R
// Ports:
//   aclk, areset     clock, synchronous active-high reset
//   s_axi_aw*/w*/ar* request channels from the master, *ready back to it
//   s_axi_b*/r*      response channels to the master, *ready from it
//   m_axi_aw*/w*/ar* request channels to the interconnect
//   m_axi_b*/r*      response channels from the interconnect
//   idle             1 when every skid channel holds no beat
//
// axi_reg_slice_ch is the 2-entry skid buffer used per channel.
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload
//   busy                          1 when either entry holds a beat

module axi_reg_slice_ch #(
    parameter int W = 8
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy
);

    logic         mv;
    logic         sv;
    logic [W-1:0] mdata;
    logic [W-1:0] sdata;
    logic         in_acc;
    logic         main_free;

    // Ready depends only on the skid flag, never on out_ready, so the
    // valid/ready path is cut. It is held low while reset is asserted.
    assign in_ready  = !sv && !areset;
    assign in_acc    = in_valid && in_ready;
    // Main entry can accept new contents this cycle.
    assign main_free = !mv || out_ready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            mv <= 1'b0;
            sv <= 1'b0;
        end else if (main_free) begin
            if (sv) begin
                mv <= 1'b1;
                sv <= 1'b0;
            end else begin
                mv <= in_acc;
            end
        end else if (in_acc) begin
            sv <= 1'b1;
        end
    end

    // Payload registers carry no reset; only the valid flags qualify them.
    always_ff @(posedge aclk) begin
        if (main_free) begin
            if (sv) begin
                mdata <= sdata;
            end else if (in_acc) begin
                mdata <= in_data;
            end
        end else if (in_acc) begin
            sdata <= in_data;
        end
    end

    assign out_valid = mv;
    assign out_data  = mdata;
    assign busy      = mv || sv;

endmodule

module axi_reg_slice #(
    parameter int         ADDR_W  = 32,
    parameter int         DATA_W  = 32,
    parameter int         ID_W    = 4,
    parameter logic [4:0] CH_MODE = 5'b11111
) (
    input  logic                aclk,
    input  logic                areset,
    // AW from master
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic                s_axi_awlock,
    input  logic [2:0]          s_axi_awprot,
    // W from master
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    // B to master
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    output logic [1:0]          s_axi_bresp,
    output logic [ID_W-1:0]     s_axi_bid,
    // AR from master
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic                s_axi_arlock,
    input  logic [2:0]          s_axi_arprot,
    // R to master
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic                s_axi_rlast,
    // AW to interconnect
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic [ID_W-1:0]     m_axi_awid,
    output logic                m_axi_awlock,
    output logic [2:0]          m_axi_awprot,
    // W to interconnect
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    // B from interconnect
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    input  logic [1:0]          m_axi_bresp,
    input  logic [ID_W-1:0]     m_axi_bid,
    // AR to interconnect
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [7:0]          m_axi_arlen,
    output logic [2:0]          m_axi_arsize,
    output logic [1:0]          m_axi_arburst,
    output logic [ID_W-1:0]     m_axi_arid,
    output logic                m_axi_arlock,
    output logic [2:0]          m_axi_arprot,
    // R from interconnect
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic [ID_W-1:0]     m_axi_rid,
    input  logic                m_axi_rlast,
    output logic                idle
);

    localparam int A_PW = ADDR_W + 8 + 3 + 2 + ID_W + 1 + 3;
    localparam int W_PW = DATA_W + DATA_W / 8 + 1;
    localparam int B_PW = 2 + ID_W;
    localparam int R_PW = DATA_W + 2 + ID_W + 1;

    logic [A_PW-1:0] aw_in, aw_out, ar_in, ar_out;
    logic [W_PW-1:0] w_in, w_out;
    logic [B_PW-1:0] b_in, b_out;
    logic [R_PW-1:0] r_in, r_out;
    logic            aw_busy, w_busy, b_busy, ar_busy, r_busy;

    assign aw_in = {s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
                    s_axi_awid, s_axi_awlock, s_axi_awprot};
    assign {m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
            m_axi_awid, m_axi_awlock, m_axi_awprot} = aw_out;
    assign w_in = {s_axi_wdata, s_axi_wstrb, s_axi_wlast};
    assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast} = w_out;
    assign b_in = {m_axi_bresp, m_axi_bid};
    assign {s_axi_bresp, s_axi_bid} = b_out;
    assign ar_in = {s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
                    s_axi_arid, s_axi_arlock, s_axi_arprot};
    assign {m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
            m_axi_arid, m_axi_arlock, m_axi_arprot} = ar_out;
    assign r_in = {m_axi_rdata, m_axi_rresp, m_axi_rid, m_axi_rlast};
    assign {s_axi_rdata, s_axi_rresp, s_axi_rid, s_axi_rlast} = r_out;

    generate
        if (CH_MODE[4]) begin : g_aw_skid
            axi_reg_slice_ch #(.W(A_PW)) u_aw (
                .aclk(aclk), .areset(areset),
                .in_valid(s_axi_awvalid), .in_ready(s_axi_awready), .in_data(aw_in),
                .out_valid(m_axi_awvalid), .out_ready(m_axi_awready), .out_data(aw_out),
                .busy(aw_busy));
        end else begin : g_aw_byp
            assign m_axi_awvalid = s_axi_awvalid;
            assign s_axi_awready = m_axi_awready;
            assign aw_out        = aw_in;
            assign aw_busy       = 1'b0;
        end

        if (CH_MODE[3]) begin : g_w_skid
            axi_reg_slice_ch #(.W(W_PW)) u_w (
                .aclk(aclk), .areset(areset),
                .in_valid(s_axi_wvalid), .in_ready(s_axi_wready), .in_data(w_in),
                .out_valid(m_axi_wvalid), .out_ready(m_axi_wready), .out_data(w_out),
                .busy(w_busy));
        end else begin : g_w_byp
            assign m_axi_wvalid = s_axi_wvalid;
            assign s_axi_wready = m_axi_wready;
            assign w_out        = w_in;
            assign w_busy       = 1'b0;
        end

        if (CH_MODE[2]) begin : g_b_skid
            axi_reg_slice_ch #(.W(B_PW)) u_b (
                .aclk(aclk), .areset(areset),
                .in_valid(m_axi_bvalid), .in_ready(m_axi_bready), .in_data(b_in),
                .out_valid(s_axi_bvalid), .out_ready(s_axi_bready), .out_data(b_out),
                .busy(b_busy));
        end else begin : g_b_byp
            assign s_axi_bvalid = m_axi_bvalid;
            assign m_axi_bready = s_axi_bready;
            assign b_out        = b_in;
            assign b_busy       = 1'b0;
        end

        if (CH_MODE[1]) begin : g_ar_skid
            axi_reg_slice_ch #(.W(A_PW)) u_ar (
                .aclk(aclk), .areset(areset),
                .in_valid(s_axi_arvalid), .in_ready(s_axi_arready), .in_data(ar_in),
                .out_valid(m_axi_arvalid), .out_ready(m_axi_arready), .out_data(ar_out),
                .busy(ar_busy));
        end else begin : g_ar_byp
            assign m_axi_arvalid = s_axi_arvalid;
            assign s_axi_arready = m_axi_arready;
            assign ar_out        = ar_in;
            assign ar_busy       = 1'b0;
        end

        if (CH_MODE[0]) begin : g_r_skid
            axi_reg_slice_ch #(.W(R_PW)) u_r (
                .aclk(aclk), .areset(areset),
                .in_valid(m_axi_rvalid), .in_ready(m_axi_rready), .in_data(r_in),
                .out_valid(s_axi_rvalid), .out_ready(s_axi_rready), .out_data(r_out),
                .busy(r_busy));
        end else begin : g_r_byp
            assign s_axi_rvalid = m_axi_rvalid;
            assign m_axi_rready = s_axi_rready;
            assign r_out        = r_in;
            assign r_busy       = 1'b0;
        end
    endgenerate

    // Built only from buffer flags, so idle carries no input-to-output path.
    assign idle = !(aw_busy || w_busy || b_busy || ar_busy || r_busy);

endmodule

// File: tb/tb_axi_reg_slice.sv
// tb/tb_axi_reg_slice.sv - randomized and directed bench for axi_reg_slice
module tb_axi_reg_slice;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // shared inputs
    logic          s_axi_awvalid, s_axi_awlock, s_axi_wvalid, s_axi_wlast, s_axi_bready;
    logic          s_axi_arvalid, s_axi_arlock, s_axi_rready;
    logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
    logic [7:0]    s_axi_awlen, s_axi_arlen;
    logic [2:0]    s_axi_awsize, s_axi_awprot, s_axi_arsize, s_axi_arprot;
    logic [1:0]    s_axi_awburst, s_axi_arburst;
    logic [IW-1:0] s_axi_awid, s_axi_arid;
    logic [DW-1:0] s_axi_wdata;
    logic [DW/8-1:0] s_axi_wstrb;
    logic          m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready;
    logic          m_axi_rvalid, m_axi_rlast;
    logic [1:0]    m_axi_bresp, m_axi_rresp;
    logic [IW-1:0] m_axi_bid, m_axi_rid;
    logic [DW-1:0] m_axi_rdata;

    // skid instance outputs
    logic          s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast;
    logic [1:0]    s_axi_bresp, s_axi_rresp;
    logic [IW-1:0] s_axi_bid, s_axi_rid;
    logic [DW-1:0] s_axi_rdata;
    logic          m_axi_awvalid, m_axi_awlock, m_axi_wvalid, m_axi_wlast, m_axi_bready;
    logic          m_axi_arvalid, m_axi_arlock, m_axi_rready, idle;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]    m_axi_awlen, m_axi_arlen;
    logic [2:0]    m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
    logic [1:0]    m_axi_awburst, m_axi_arburst;
    logic [IW-1:0] m_axi_awid, m_axi_arid;
    logic [DW-1:0] m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;

    // bypass instance outputs
    logic          bp_s_axi_awready, bp_s_axi_wready, bp_s_axi_bvalid, bp_s_axi_arready, bp_s_axi_rvalid, bp_s_axi_rlast;
    logic [1:0]    bp_s_axi_bresp, bp_s_axi_rresp;
    logic [IW-1:0] bp_s_axi_bid, bp_s_axi_rid;
    logic [DW-1:0] bp_s_axi_rdata;
    logic          bp_m_axi_awvalid, bp_m_axi_awlock, bp_m_axi_wvalid, bp_m_axi_wlast, bp_m_axi_bready;
    logic          bp_m_axi_arvalid, bp_m_axi_arlock, bp_m_axi_rready, bp_idle;
    logic [AW-1:0] bp_m_axi_awaddr, bp_m_axi_araddr;
    logic [7:0]    bp_m_axi_awlen, bp_m_axi_arlen;
    logic [2:0]    bp_m_axi_awsize, bp_m_axi_awprot, bp_m_axi_arsize, bp_m_axi_arprot;
    logic [1:0]    bp_m_axi_awburst, bp_m_axi_arburst;
    logic [IW-1:0] bp_m_axi_awid, bp_m_axi_arid;
    logic [DW-1:0] bp_m_axi_wdata;
    logic [DW/8-1:0] bp_m_axi_wstrb;

    axi_reg_slice #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .CH_MODE(5'b11111)) dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
        .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awid(s_axi_awid), .s_axi_awlock(s_axi_awlock), .s_axi_awprot(s_axi_awprot),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp), .s_axi_bid(s_axi_bid),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
        .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arid(s_axi_arid), .s_axi_arlock(s_axi_arlock), .s_axi_arprot(s_axi_arprot),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp), .s_axi_rid(s_axi_rid), .s_axi_rlast(s_axi_rlast),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awid(m_axi_awid), .m_axi_awlock(m_axi_awlock), .m_axi_awprot(m_axi_awprot),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp), .m_axi_bid(m_axi_bid),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arid(m_axi_arid), .m_axi_arlock(m_axi_arlock), .m_axi_arprot(m_axi_arprot),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rid(m_axi_rid), .m_axi_rlast(m_axi_rlast),
        .idle(idle));

    axi_reg_slice #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .CH_MODE(5'b00000)) dut_bp (
        .aclk(aclk), .areset(areset),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(bp_s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
        .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awid(s_axi_awid), .s_axi_awlock(s_axi_awlock), .s_axi_awprot(s_axi_awprot),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(bp_s_axi_wready), .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_bvalid(bp_s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(bp_s_axi_bresp), .s_axi_bid(bp_s_axi_bid),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(bp_s_axi_arready), .s_axi_araddr(s_axi_araddr),
        .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arid(s_axi_arid), .s_axi_arlock(s_axi_arlock), .s_axi_arprot(s_axi_arprot),
        .s_axi_rvalid(bp_s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(bp_s_axi_rdata),
        .s_axi_rresp(bp_s_axi_rresp), .s_axi_rid(bp_s_axi_rid), .s_axi_rlast(bp_s_axi_rlast),
        .m_axi_awvalid(bp_m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(bp_m_axi_awaddr),
        .m_axi_awlen(bp_m_axi_awlen), .m_axi_awsize(bp_m_axi_awsize), .m_axi_awburst(bp_m_axi_awburst),
        .m_axi_awid(bp_m_axi_awid), .m_axi_awlock(bp_m_axi_awlock), .m_axi_awprot(bp_m_axi_awprot),
        .m_axi_wvalid(bp_m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(bp_m_axi_wdata),
        .m_axi_wstrb(bp_m_axi_wstrb), .m_axi_wlast(bp_m_axi_wlast),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(bp_m_axi_bready), .m_axi_bresp(m_axi_bresp), .m_axi_bid(m_axi_bid),
        .m_axi_arvalid(bp_m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(bp_m_axi_araddr),
        .m_axi_arlen(bp_m_axi_arlen), .m_axi_arsize(bp_m_axi_arsize), .m_axi_arburst(bp_m_axi_arburst),
        .m_axi_arid(bp_m_axi_arid), .m_axi_arlock(bp_m_axi_arlock), .m_axi_arprot(bp_m_axi_arprot),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(bp_m_axi_rready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rid(m_axi_rid), .m_axi_rlast(m_axi_rlast),
        .idle(bp_idle));

    // R scoreboard: beats accepted upstream and not yet delivered downstream
    logic [DW+2+IW:0] rq[$];
    logic             in_fire, out_fire;
    int               pushed, cyc;

    initial begin
        areset = 1'b1;
        {s_axi_awvalid, s_axi_awlock, s_axi_wvalid, s_axi_wlast, s_axi_arvalid, s_axi_arlock} = '0;
        {s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awprot, s_axi_awburst, s_axi_awid} = '0;
        {s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arprot, s_axi_arburst, s_axi_arid} = '0;
        s_axi_wdata = '0; s_axi_wstrb = '1;
        {m_axi_bvalid, m_axi_rvalid, m_axi_rlast, m_axi_bresp, m_axi_rresp, m_axi_bid, m_axi_rid} = '0;
        m_axi_rdata = '0;
        {m_axi_awready, m_axi_wready, m_axi_arready, s_axi_bready, s_axi_rready} = 5'b11111;

        // reset with a valid request pending
        s_axi_awvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("rst_awready", s_axi_awready, 1'b0);
            check("rst_m_awvalid", m_axi_awvalid, 1'b0);
            check("rst_idle", idle, 1'b1);
        end
        areset = 1'b0;
        s_axi_awvalid = 1'b0;
        #1;
        check("rel_awready", s_axi_awready, 1'b1);
        check("rel_wready", s_axi_wready, 1'b1);
        check("rel_arready", s_axi_arready, 1'b1);
        check("rel_bready", m_axi_bready, 1'b1);
        check("rel_rready", m_axi_rready, 1'b1);

        // W stream, 16 beats, one cycle latency
        for (int k = 0; k <= 16; k++) begin
            @(negedge aclk);
            if (k > 0) begin
                check("w_valid", m_axi_wvalid, 1'b1);
                check("w_data", m_axi_wdata, 64'(k - 1));
                check("w_last", m_axi_wlast, (k == 16));
                check("w_ready", s_axi_wready, 1'b1);
            end
            s_axi_wvalid = (k < 16);
            s_axi_wdata  = 64'(k);
            s_axi_wlast  = (k == 15);
        end
        @(negedge aclk);
        check("w_drained", m_axi_wvalid, 1'b0);

        // AR backpressure: two beats held, then released in order
        m_axi_arready = 1'b0;
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = 32'h1000;
        @(negedge aclk);
        check("ar_ready_1", s_axi_arready, 1'b1);
        check("ar_addr_1", m_axi_araddr, 32'h1000);
        s_axi_araddr = 32'h2000;
        @(negedge aclk);
        check("ar_full_ready", s_axi_arready, 1'b0);
        check("ar_full_idle", idle, 1'b0);
        check("ar_full_valid", m_axi_arvalid, 1'b1);
        check("ar_full_addr", m_axi_araddr, 32'h1000);
        s_axi_arvalid = 1'b0;
        @(negedge aclk);
        check("ar_stall_ready", s_axi_arready, 1'b0);
        check("ar_stall_addr", m_axi_araddr, 32'h1000);
        m_axi_arready = 1'b1;
        @(negedge aclk);
        check("ar_second_valid", m_axi_arvalid, 1'b1);
        check("ar_second_addr", m_axi_araddr, 32'h2000);
        @(negedge aclk);
        check("ar_drained", m_axi_arvalid, 1'b0);
        check("ar_idle", idle, 1'b1);

        // R random traffic against a queue model
        pushed  = 0;
        cyc     = 0;
        in_fire = 1'b0;
        m_axi_rvalid = 1'b0;
        while ((pushed < 1000 || rq.size() > 0) && cyc < 8000) begin
            @(negedge aclk);
            cyc++;
            check("r_valid", s_axi_rvalid, rq.size() > 0);
            check("r_ready", m_axi_rready, rq.size() < 2);
            check("r_idle", idle, rq.size() == 0);
            if (rq.size() > 0 && s_axi_rvalid)
                check("r_payload", {s_axi_rdata, s_axi_rresp, s_axi_rid, s_axi_rlast}, rq[0]);
            // an offered beat that was not taken must be held unchanged
            if (!(m_axi_rvalid && !in_fire)) begin
                m_axi_rvalid = (pushed < 1000) && ($urandom_range(0, 9) < 6);
                m_axi_rdata  = {$urandom, $urandom};
                m_axi_rresp  = 2'($urandom);
                m_axi_rid    = 4'($urandom);
                m_axi_rlast  = 1'($urandom);
            end
            s_axi_rready = 1'($urandom);
            #1;
            in_fire  = m_axi_rvalid && m_axi_rready;
            out_fire = s_axi_rvalid && s_axi_rready;
            if (out_fire) void'(rq.pop_front());
            if (in_fire) begin
                rq.push_back({m_axi_rdata, m_axi_rresp, m_axi_rid, m_axi_rlast});
                pushed++;
            end
        end
        check("r_all_delivered", (pushed == 1000) && (rq.size() == 0), 1'b1);
        m_axi_rvalid = 1'b0;
        s_axi_rready = 1'b1;

        // bypass instance: B passes straight through in the same cycle
        @(negedge aclk);
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = 2'b10;
        m_axi_bid    = 4'hA;
        s_axi_bready = 1'b0;
        #1;
        check("bp_bvalid", bp_s_axi_bvalid, 1'b1);
        check("bp_bresp", bp_s_axi_bresp, 2'b10);
        check("bp_bid", bp_s_axi_bid, 4'hA);
        check("bp_bready_0", bp_m_axi_bready, 1'b0);
        check("bp_idle", bp_idle, 1'b1);
        check("skid_b_latency", s_axi_bvalid, 1'b0);
        s_axi_bready = 1'b1;
        #1;
        check("bp_bready_1", bp_m_axi_bready, 1'b1);
        @(negedge aclk);
        m_axi_bvalid = 1'b0;
        #1;
        check("bp_bvalid_0", bp_s_axi_bvalid, 1'b0);
        check("bp_idle_end", bp_idle, 1'b1);
        @(negedge aclk);

        // AW mid-stream reset discards both buffered beats
        m_axi_awready = 1'b0;
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = 32'hA0;
        @(negedge aclk);
        s_axi_awaddr = 32'hB0;
        @(negedge aclk);
        s_axi_awvalid = 1'b0;
        check("aw_held_valid", m_axi_awvalid, 1'b1);
        check("aw_held_addr", m_axi_awaddr, 32'hA0);
        check("aw_held_ready", s_axi_awready, 1'b0);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        check("aw_rst_valid", m_axi_awvalid, 1'b0);
        check("aw_rst_idle", idle, 1'b1);
        m_axi_awready = 1'b1;
        #1;
        check("aw_rst_ready", s_axi_awready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("aw_no_stale", m_axi_awvalid, 1'b0);
        end
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = 32'hC0;
        @(negedge aclk);
        s_axi_awvalid = 1'b0;
        check("aw_new_valid", m_axi_awvalid, 1'b1);
        check("aw_new_addr", m_axi_awaddr, 32'hC0);
        @(negedge aclk);
        check("aw_new_drained", m_axi_awvalid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
